// File: rtl/alu_arbiter_pkg.sv
// Shared definitions for the two-requester ALU arbiter.
// Holds the state encoding, opcode set, default width and requester ids.
package alu_arbiter_pkg;

  localparam int WIDTH_DEF = 32;
  localparam int OP_W      = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EXEC = 2'b01,
    ST_RESP = 2'b10
  } state_e;

  typedef enum logic [OP_W-1:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_OR  = 3'b011,
    OP_XOR = 3'b100,
    OP_SLL = 3'b101,
    OP_SRL = 3'b110,
    OP_SLT = 3'b111
  } op_e;

  localparam logic ID_REQ0 = 1'b0;
  localparam logic ID_REQ1 = 1'b1;

endpackage

// File: rtl/alu_arbiter_alu.sv
// Existing combinational ALU shared by both requesters.
// Shifts use the low log2(WIDTH) bits of b; SLT is an unsigned compare.
module alu_arbiter_alu
  import alu_arbiter_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic [0:WIDTH-1] a_in,
  input  logic [0:WIDTH-1] b_in,
  input  logic [OP_W-1:0]  op_in,
  output logic [0:WIDTH-1] y_out,
  output logic             z_out
);

  localparam int SH_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic [SH_W-1:0]  shamt_s;
  logic [0:WIDTH-1] y_s;

  assign shamt_s = SH_W'(b_in);

  // Operation select
  always_comb begin
    y_s = '0;
    case (op_e'(op_in))
      OP_ADD:  y_s = a_in + b_in;
      OP_SUB:  y_s = a_in - b_in;
      OP_AND:  y_s = a_in & b_in;
      OP_OR:   y_s = a_in | b_in;
      OP_XOR:  y_s = a_in ^ b_in;
      OP_SLL:  y_s = a_in << shamt_s;
      OP_SRL:  y_s = a_in >> shamt_s;
      OP_SLT:  y_s = (a_in < b_in) ? {{(WIDTH-1){1'b0}}, 1'b1} : '0;
      default: y_s = '0;
    endcase
  end

  assign y_out = y_s;
  assign z_out = (y_s == '0);

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter granting one shared ALU to two requesters.
// Each operation takes IDLE (grant) -> EXEC -> RESP, with a one-cycle ack in RESP.
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             req0_in,
  input  logic [0:WIDTH-1] a0_in,
  input  logic [0:WIDTH-1] b0_in,
  input  logic [OP_W-1:0]  op0_in,
  input  logic             req1_in,
  input  logic [0:WIDTH-1] a1_in,
  input  logic [0:WIDTH-1] b1_in,
  input  logic [OP_W-1:0]  op1_in,
  output logic             ack0_out,
  output logic             ack1_out,
  output logic [0:WIDTH-1] y_out,
  output logic             z_out,
  output logic             gnt_id_out,
  output logic             busy_out
);

  state_e           state_r, state_s;
  logic             rr_r;
  logic             gnt_id_r;
  logic             busy_r;
  logic             ack0_r, ack1_r;
  logic [0:WIDTH-1] a_r, b_r, y_r;
  logic [OP_W-1:0]  op_r;
  logic             z_r;

  logic             grant_s;
  logic             grant_id_s;
  logic [0:WIDTH-1] sel_a_s, sel_b_s;
  logic [OP_W-1:0]  sel_op_s;
  logic [0:WIDTH-1] alu_y_s;
  logic             alu_z_s;

  // Arbitration: a lone request wins, contention goes to the rr pointer
  always_comb begin
    grant_s    = 1'b0;
    grant_id_s = ID_REQ0;
    if (req0_in && req1_in) begin
      grant_s    = 1'b1;
      grant_id_s = rr_r;
    end else if (req0_in) begin
      grant_s    = 1'b1;
      grant_id_s = ID_REQ0;
    end else if (req1_in) begin
      grant_s    = 1'b1;
      grant_id_s = ID_REQ1;
    end else begin
      grant_s    = 1'b0;
      grant_id_s = ID_REQ0;
    end
  end

  // Operand mux for the winning requester
  always_comb begin
    sel_a_s  = a0_in;
    sel_b_s  = b0_in;
    sel_op_s = op0_in;
    if (grant_id_s == ID_REQ1) begin
      sel_a_s  = a1_in;
      sel_b_s  = b1_in;
      sel_op_s = op1_in;
    end else begin
      sel_a_s  = a0_in;
      sel_b_s  = b0_in;
      sel_op_s = op0_in;
    end
  end

  // Next-state logic
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (grant_s) begin
          state_s = ST_EXEC;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_EXEC: state_s = ST_RESP;
      ST_RESP: state_s = ST_IDLE;
      default: state_s = ST_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Grant latch, result capture and ack/busy generation
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      rr_r     <= ID_REQ0;
      gnt_id_r <= ID_REQ0;
      busy_r   <= 1'b0;
      ack0_r   <= 1'b0;
      ack1_r   <= 1'b0;
      a_r      <= '0;
      b_r      <= '0;
      op_r     <= '0;
      y_r      <= '0;
      z_r      <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          ack0_r <= 1'b0;
          ack1_r <= 1'b0;
          if (grant_s) begin
            a_r      <= sel_a_s;
            b_r      <= sel_b_s;
            op_r     <= sel_op_s;
            gnt_id_r <= grant_id_s;
            rr_r     <= ~grant_id_s;
            busy_r   <= 1'b1;
          end else begin
            busy_r   <= 1'b0;
          end
        end
        ST_EXEC: begin
          y_r    <= alu_y_s;
          z_r    <= alu_z_s;
          ack0_r <= (gnt_id_r == ID_REQ0);
          ack1_r <= (gnt_id_r == ID_REQ1);
          busy_r <= 1'b1;
        end
        ST_RESP: begin
          ack0_r <= 1'b0;
          ack1_r <= 1'b0;
          busy_r <= 1'b0;
        end
        default: begin
          ack0_r <= 1'b0;
          ack1_r <= 1'b0;
          busy_r <= 1'b0;
        end
      endcase
    end
  end

  // The ALU only ever sees latched operands, so late input changes cannot leak in
  alu_arbiter_alu #(
    .WIDTH (WIDTH)
  ) u_alu (
    .a_in  (a_r),
    .b_in  (b_r),
    .op_in (op_r),
    .y_out (alu_y_s),
    .z_out (alu_z_s)
  );

  assign ack0_out   = ack0_r;
  assign ack1_out   = ack1_r;
  assign y_out      = y_r;
  assign z_out      = z_r;
  assign gnt_id_out = gnt_id_r;
  assign busy_out   = busy_r;

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: directed vector table, multi-cycle
// sequences, and randomized traffic against a transaction-level reference model.
module tb_alu_arbiter;

  localparam int W = 32;

  logic         clk_in = 1'b0;
  logic         rst_in;
  logic         req0_in, req1_in;
  logic [0:W-1] a0_in, b0_in, a1_in, b1_in;
  logic [2:0]   op0_in, op1_in;
  logic         ack0_out, ack1_out, z_out, gnt_id_out, busy_out;
  logic [0:W-1] y_out;

  int errors = 0;
  int checks = 0;
  int low_run, max_low;

  always #5 clk_in = ~clk_in;

  alu_arbiter #(.WIDTH(W)) dut (
    .clk_in(clk_in), .rst_in(rst_in),
    .req0_in(req0_in), .a0_in(a0_in), .b0_in(b0_in), .op0_in(op0_in),
    .req1_in(req1_in), .a1_in(a1_in), .b1_in(b1_in), .op1_in(op1_in),
    .ack0_out(ack0_out), .ack1_out(ack1_out), .y_out(y_out), .z_out(z_out),
    .gnt_id_out(gnt_id_out), .busy_out(busy_out)
  );

  typedef struct {
    logic        req0;
    logic [31:0] a0, b0;
    logic [2:0]  op0;
    logic        req1;
    logic [31:0] a1, b1;
    logic [2:0]  op1;
    logic        exp_id;
    logic [31:0] exp_y;
    logic        exp_z;
  } vec_t;

  vec_t vecs[12];

  function automatic logic [31:0] alu_ref(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      3'd0:    return a + b;
      3'd1:    return a - b;
      3'd2:    return a & b;
      3'd3:    return a | b;
      3'd4:    return a ^ b;
      3'd5:    return a << (b % 32);
      3'd6:    return a >> (b % 32);
      default: return (a < b) ? 32'd1 : 32'd0;
    endcase
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic do_reset();
    rst_in  = 1'b1;
    req0_in = 1'b0;
    req1_in = 1'b0;
    tick();
    tick();
    check("rst_ack0", ack0_out, 0);
    check("rst_ack1", ack1_out, 0);
    check("rst_busy", busy_out, 0);
    check("rst_gnt", gnt_id_out, 0);
    check("rst_y", y_out, 0);
    check("rst_z", z_out, 0);
    rst_in = 1'b0;
  endtask

  task automatic wait_ack(output logic got, output logic id);
    got = 1'b0;
    id  = 1'b0;
    for (int i = 0; i < 12 && !got; i++) begin
      tick();
      check("ack_exclusive", ack0_out & ack1_out, 0);
      if (!busy_out) begin
        low_run++;
        if (low_run > max_low) max_low = low_run;
      end else begin
        low_run = 0;
      end
      if (ack0_out || ack1_out) begin
        got = 1'b1;
        id  = ack1_out;
      end
    end
    if (!got) check("ack_timeout", 0, 1);
  endtask

  task automatic run_vec(input vec_t v);
    do_reset();
    req0_in = v.req0; a0_in = v.a0; b0_in = v.b0; op0_in = v.op0;
    req1_in = v.req1; a1_in = v.a1; b1_in = v.b1; op1_in = v.op1;
    tick();
    check("vec_gnt", gnt_id_out, v.exp_id);
    check("vec_busy_exec", busy_out, 1);
    check("vec_noack_exec", {ack0_out, ack1_out}, 0);
    req0_in = 1'b0; req1_in = 1'b0;
    a0_in = 32'd100; a1_in = 32'd100; b0_in = $urandom; b1_in = $urandom;
    op0_in = 3'($urandom); op1_in = 3'($urandom);
    tick();
    check("vec_ack0", ack0_out, (v.exp_id == 1'b0));
    check("vec_ack1", ack1_out, (v.exp_id == 1'b1));
    check("vec_y", y_out, v.exp_y);
    check("vec_z", z_out, v.exp_z);
    tick();
    check("vec_ack_clear", {ack0_out, ack1_out}, 0);
    check("vec_busy_idle", busy_out, 0);
    check("vec_y_hold", y_out, v.exp_y);
  endtask

  logic        got, id;
  int          m_left;
  logic        m_rr, m_owner, m_busy, m_ack0, m_ack1, m_z;
  logic [31:0] m_y, m_res;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst_in = 1'b1; req0_in = 1'b0; req1_in = 1'b0;
    a0_in = '0; b0_in = '0; a1_in = '0; b1_in = '0; op0_in = '0; op1_in = '0;
    low_run = 0; max_low = 0;

    //          req0 a0            b0            op0   req1 a1            b1            op1   id    y             z
    vecs[0]  = '{1'b1, 32'd1,        32'd1,        3'd0, 1'b0, 32'd0,        32'd0,        3'd0, 1'b0, 32'd2,        1'b0};
    vecs[1]  = '{1'b1, 32'd0,        32'd0,        3'd0, 1'b0, 32'd9,        32'd9,        3'd0, 1'b0, 32'd0,        1'b1};
    vecs[2]  = '{1'b0, 32'd0,        32'd0,        3'd0, 1'b1, 32'd3,        32'd4,        3'd0, 1'b1, 32'd7,        1'b0};
    vecs[3]  = '{1'b1, 32'd5,        32'd7,        3'd1, 1'b0, 32'd0,        32'd0,        3'd0, 1'b0, 32'hFFFFFFFE, 1'b0};
    vecs[4]  = '{1'b0, 32'd0,        32'd0,        3'd0, 1'b1, 32'hF0F01234, 32'h0FF0FFFF, 3'd2, 1'b1, 32'h00F01234, 1'b0};
    vecs[5]  = '{1'b1, 32'h80000000, 32'h00000001, 3'd3, 1'b0, 32'd0,        32'd0,        3'd0, 1'b0, 32'h80000001, 1'b0};
    vecs[6]  = '{1'b0, 32'd0,        32'd0,        3'd0, 1'b1, 32'hAAAAAAAA, 32'hAAAAAAAA, 3'd4, 1'b1, 32'd0,        1'b1};
    vecs[7]  = '{1'b1, 32'd1,        32'd33,       3'd5, 1'b0, 32'd0,        32'd0,        3'd0, 1'b0, 32'd2,        1'b0};
    vecs[8]  = '{1'b0, 32'd0,        32'd0,        3'd0, 1'b1, 32'h80000000, 32'd31,       3'd6, 1'b1, 32'd1,        1'b0};
    vecs[9]  = '{1'b1, 32'd3,        32'd9,        3'd7, 1'b0, 32'd0,        32'd0,        3'd0, 1'b0, 32'd1,        1'b0};
    vecs[10] = '{1'b1, 32'd1,        32'd1,        3'd0, 1'b1, 32'd5,        32'd7,        3'd0, 1'b0, 32'd2,        1'b0};
    vecs[11] = '{1'b1, 32'hFFFFFFFF, 32'd1,        3'd0, 1'b0, 32'd0,        32'd0,        3'd0, 1'b0, 32'd0,        1'b1};

    for (int i = 0; i < 12; i++) run_vec(vecs[i]);

    // Sustained contention: strict alternation with at most one idle cycle between ops
    do_reset();
    req0_in = 1'b1; a0_in = 32'd1; b0_in = 32'd1; op0_in = 3'd0;
    req1_in = 1'b1; a1_in = 32'd5; b1_in = 32'd7; op1_in = 3'd0;
    low_run = 0; max_low = 0;
    for (int k = 0; k < 6; k++) begin
      wait_ack(got, id);
      check("alt_got", got, 1);
      check("alt_id", id, k % 2);
      check("alt_y", y_out, (k % 2) ? 32'd12 : 32'd2);
    end
    check("alt_busy_gap", max_low, 1);
    req0_in = 1'b0; req1_in = 1'b0;

    // Reset in EXEC discards the op and restores the pointer to requester 0
    do_reset();
    req0_in = 1'b1; a0_in = 32'd2; b0_in = 32'd2; op0_in = 3'd0;
    tick();
    check("rx_busy", busy_out, 1);
    rst_in = 1'b1;
    tick();
    check("rx_ack0", ack0_out, 0);
    check("rx_busy_rst", busy_out, 0);
    check("rx_y_rst", y_out, 0);
    check("rx_gnt_rst", gnt_id_out, 0);
    tick();
    check("rx_req_ignored", busy_out, 0);
    rst_in = 1'b0; req0_in = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("rx_no_ack", {ack0_out, ack1_out}, 0);
    end
    req0_in = 1'b1; a0_in = 32'd1; b0_in = 32'd1;
    req1_in = 1'b1; a1_in = 32'd5; b1_in = 32'd7;
    wait_ack(got, id);
    check("rx_after_id", id, 0);
    check("rx_after_y", y_out, 32'd2);
    req0_in = 1'b0; req1_in = 1'b0;
    tick();
    tick();

    // Randomized traffic against the transaction-level model
    m_left = 0; m_rr = 0; m_owner = 0; m_busy = 0; m_ack0 = 0; m_ack1 = 0; m_y = 0; m_z = 0; m_res = 0;
    for (int c = 0; c < 400; c++) begin
      rst_in  = (c == 0) || ($urandom_range(0, 59) == 0);
      req0_in = ($urandom_range(0, 3) != 0);
      req1_in = ($urandom_range(0, 3) != 0);
      a0_in   = $urandom;
      b0_in   = $urandom_range(0, 1) ? $urandom : $urandom_range(0, 40);
      a1_in   = ($urandom_range(0, 3) == 0) ? a0_in : $urandom;
      b1_in   = ($urandom_range(0, 3) == 0) ? a1_in : $urandom;
      op0_in  = 3'($urandom_range(0, 7));
      op1_in  = 3'($urandom_range(0, 7));
      if (rst_in) begin
        m_left = 0; m_rr = 0; m_owner = 0; m_busy = 0;
        m_ack0 = 0; m_ack1 = 0; m_y = 0; m_z = 0;
      end else if (m_left == 0) begin
        m_ack0 = 0; m_ack1 = 0;
        if (req0_in || req1_in) begin
          m_owner = (req0_in && req1_in) ? m_rr : req1_in;
          m_res   = m_owner ? alu_ref(op1_in, a1_in, b1_in) : alu_ref(op0_in, a0_in, b0_in);
          m_rr    = !m_owner;
          m_busy  = 1;
          m_left  = 2;
        end else begin
          m_busy = 0;
        end
      end else if (m_left == 2) begin
        m_y    = m_res;
        m_z    = (m_res == 32'd0);
        m_ack0 = !m_owner;
        m_ack1 = m_owner;
        m_left = 1;
      end else begin
        m_ack0 = 0; m_ack1 = 0; m_busy = 0;
        m_left = 0;
      end
      tick();
      check("rnd_y", y_out, m_y);
      check("rnd_z", z_out, m_z);
      check("rnd_ack0", ack0_out, m_ack0);
      check("rnd_ack1", ack1_out, m_ack1);
      check("rnd_gnt", gnt_id_out, m_owner);
      check("rnd_busy", busy_out, m_busy);
      check("rnd_exclusive", ack0_out & ack1_out, 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter: WIDTH, 32, operand/result width in bits; all vectors use [0:WIDTH-1] ordering, bit 0 MSB.
REQ-002 clk_in  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_in  input  1  reset, synchronous, active-high.
REQ-004 req0_in  input  1  requester 0 request (level, held until ack0_out).
REQ-005 a0_in, b0_in  input  WIDTH  requester 0 operands.
REQ-006 op0_in  input  3  requester 0 ALU opcode.
REQ-007 req1_in, a1_in, b1_in, op1_in  input  1/WIDTH/WIDTH/3  requester 1, same meanings.
REQ-008 ack0_out, ack1_out  output  1  one-cycle result-valid pulse to the owning requester.
REQ-009 y_out  output  WIDTH  registered ALU result; valid while an ack is high.
REQ-010 z_out  output  1  registered ALU zero flag; valid while an ack is high.
REQ-011 gnt_id_out  output  1  id of the requester currently owning the ALU.
REQ-012 busy_out  output  1  high in EXEC and RESP.

Function
REQ-013 FSM states IDLE, EXEC, RESP; one operation occupies exactly 3 cycles.
REQ-014 IDLE: no request -> stay IDLE; one request -> grant it; both -> grant requester indicated by rr pointer; on grant latch a/b/op and id, go EXEC.
REQ-015 rr pointer SHALL point at the non-granted requester after every grant (strict alternation under contention).
REQ-016 EXEC: ALU driven from latched operands only; y_out/z_out registered from ALU at end of EXEC; go RESP.
REQ-017 RESP: ack of the granted id high for exactly this cycle, other ack low; go IDLE.
REQ-018 Latency: request granted at edge E0 -> ack high between E2... specifically ack asserted after E1, deasserted at E2.
REQ-019 Operand/op changes on any input after grant SHALL NOT affect the in-flight result.
REQ-020 Requester dropping req after grant does not cancel; op completes and ack still pulses.
REQ-021 Request still high when FSM re-enters IDLE is a new request and is arbitrated normally.
REQ-022 y_out/z_out hold last result until next EXEC completion.
REQ-023 Width: y_out is ALU output unmodified; no extension or saturation in this block.
REQ-024 ack0_out and ack1_out SHALL never be high simultaneously.

Reset
REQ-025 rst_in high at any edge: state IDLE, rr pointer 0, gnt_id_out 0, busy_out 0, ack0/ack1 0, y_out 0, z_out 0.
REQ-026 Reset during EXEC or RESP discards the operation; no ack issued for it.
REQ-027 Requests present while rst_in high are ignored; arbitration starts on first edge with rst_in low.

Structure
REQ-028 Shared package holds state encoding, opcode width (3), WIDTH default, and requester id constants.
REQ-029 Exactly one sub-module: existing ALU (ports a_in, b_in, op_in, y_out, z_out), instantiated once, inputs from latched registers.
REQ-030 No other ALU instance; arbitration and FSM stay in alu_arbiter.

Verification
REQ-031 Reset then req0 with a0=1, b0=1, op0=000 -> ack0 pulses 3 cycles after grant edge sequence, y_out=2, z_out=0, ack1 never high.
REQ-032 req0 and req1 asserted same cycle after reset (a0=1,b0=1; a1=5,b1=7; op=000) -> req0 served first (y=2), then req1 (y=12), acks in that order.
REQ-033 Both requests held continuously for 6 operations -> acks alternate 0,1,0,1,0,1; busy_out never low for more than one cycle between ops.
REQ-034 Grant req1 (a1=3,b1=4,op=000), change a1 to 100 during EXEC -> y_out=7.
REQ-035 Assert rst_in during EXEC of req0 -> no ack0, outputs at reset values next cycle, next request served from pointer 0.
REQ-036 a0=0, b0=0, op0=000 -> y_out=0, z_out=1 with ack0.
